mult_accumulator: RTL and testbench

Sequential accumulator directly downstream of the 2-bit multiplier. It accepts a fixed-length batch of 4-bit products on its `C` input and sums them into a saturating register. When the batch completes, it presents the total on `SUM` with a one-cycle `sum_valid` strobe. It converts the combinational multiplier into a batched multiply-accumulate path for display or later processing stages.

---
 rtl/mult_pkg.sv | 11 +
 rtl/mult_accumulator_sat_add.sv | 22 ++
 rtl/mult_accumulator.sv | 80 ++++++++
 tb/tb_mult_accumulator.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier and its batch accumulator.
// State encoding and product width.
package mult_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int PROD_W = 4;

endpackage

// File: rtl/mult_accumulator_sat_add.sv
// Saturating adder: ACC_W-bit accumulator plus a PROD_W-bit product.
// Clamps to all ones and flags sat when the sum leaves ACC_W bits.
module sat_add
    import mult_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [PROD_W-1:0] b,
    output logic [ACC_W-1:0]  y,
    output logic              sat
);

    logic [ACC_W:0] sum;

    always_comb begin
        sum = {1'b0, a} + {{(ACC_W + 1 - PROD_W){1'b0}}, b};
        sat = sum[ACC_W];
        y   = sat ? '1 : sum[ACC_W-1:0];
    end

endmodule

// File: rtl/mult_accumulator.sv
// Batched saturating accumulator for multiplier products.
// Sums COUNT accepted beats, then publishes SUM with a sum_valid strobe.
module mult_accumulator
    import mult_pkg::*;
#(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] C,
    output logic              in_ready,
    output logic [ACC_W-1:0]  SUM,
    output logic              sum_valid,
    output logic              overflow,
    output logic              busy
);

    localparam logic [7:0] LAST = 8'(COUNT - 1);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic             sat;

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (C),
        .y   (acc_nxt),
        .sat (sat)
    );

    assign in_ready = (state == S_ACCUM);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            SUM       <= '0;
            overflow  <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_nxt;
                        ovf <= ovf | sat;
                        cnt <= cnt + 8'd1;
                        if (cnt == LAST)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    SUM       <= acc;
                    overflow  <= ovf;
                    sum_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: three instances cover
// default, narrow (ACC_W=5) and single-beat (COUNT=1) configurations.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start_v;
    logic [2:0] iv_v;
    logic [3:0] c_v [3];
    logic [2:0] rdy_v;
    logic [2:0] sv_v;
    logic [2:0] ovf_v;
    logic [2:0] busy_v;
    logic [7:0] sum_a;
    logic [4:0] sum_b;
    logic [7:0] sum_c;
    int         sum_v [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_accumulator u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(iv_v[0]),
        .C(c_v[0]), .in_ready(rdy_v[0]), .SUM(sum_a), .sum_valid(sv_v[0]),
        .overflow(ovf_v[0]), .busy(busy_v[0])
    );

    mult_accumulator #(.ACC_W(5)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(iv_v[1]),
        .C(c_v[1]), .in_ready(rdy_v[1]), .SUM(sum_b), .sum_valid(sv_v[1]),
        .overflow(ovf_v[1]), .busy(busy_v[1])
    );

    mult_accumulator #(.COUNT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(iv_v[2]),
        .C(c_v[2]), .in_ready(rdy_v[2]), .SUM(sum_c), .sum_valid(sv_v[2]),
        .overflow(ovf_v[2]), .busy(busy_v[2])
    );

    always_comb begin
        sum_v[0] = int'(sum_a);
        sum_v[1] = int'(sum_b);
        sum_v[2] = int'(sum_c);
    end

    typedef struct {
        int             d;
        int             n;
        logic [3:0][3:0] c;
        int             sum;
        int             ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_batch(input int d, input int n,
                             input logic [3:0][3:0] c,
                             input int exp_sum, input int exp_ovf,
                             input bit hold);
        start_v[d] = 1'b1;
        step();
        start_v[d] = 1'b0;
        chk("accum_ready", int'(rdy_v[d]), 1);
        for (int i = 0; i < n; i++) begin
            c_v[d]  = c[i];
            iv_v[d] = 1'b1;
            step();
        end
        if (hold) c_v[d] = 4'd9;
        else iv_v[d] = 1'b0;
        chk("done_ready", int'(rdy_v[d]), 0);
        chk("done_sv", int'(sv_v[d]), 0);
        chk("done_busy", int'(busy_v[d]), 1);
        step();
        chk("sv_high", int'(sv_v[d]), 1);
        chk("sum", sum_v[d], exp_sum);
        chk("ovf", int'(ovf_v[d]), exp_ovf);
        chk("idle_busy", int'(busy_v[d]), 0);
        step();
        chk("sv_low", int'(sv_v[d]), 0);
        chk("sum_hold", sum_v[d], exp_sum);
        iv_v[d] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{d: 0, n: 4, c: {4'd0, 4'd9, 4'd9, 4'd2}, sum: 20, ovf: 0};
        vecs[1] = '{d: 1, n: 4, c: {4'd9, 4'd9, 4'd9, 4'd9}, sum: 31, ovf: 1};
        vecs[2] = '{d: 1, n: 4, c: {4'd1, 4'd1, 4'd1, 4'd1}, sum: 4,  ovf: 0};
        vecs[3] = '{d: 0, n: 4, c: {4'd15, 4'd15, 4'd15, 4'd15}, sum: 60, ovf: 0};
        vecs[4] = '{d: 1, n: 4, c: {4'd7, 4'd9, 4'd8, 4'd7}, sum: 31, ovf: 0};
        vecs[5] = '{d: 2, n: 1, c: {4'd0, 4'd0, 4'd0, 4'd6}, sum: 6,  ovf: 0};
        vecs[6] = '{d: 1, n: 4, c: {4'd15, 4'd15, 4'd15, 4'd15}, sum: 31, ovf: 1};

        rst_n   = 1'b0;
        start_v = '0;
        iv_v    = '0;
        for (int i = 0; i < 3; i++) c_v[i] = '0;
        step();
        step();
        chk("rst_ready", int'(rdy_v[0]), 0);
        chk("rst_sum", sum_v[0], 0);
        chk("rst_sv", int'(sv_v[0]), 0);
        chk("rst_ovf", int'(ovf_v[0]), 0);
        chk("rst_busy", int'(busy_v[0]), 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 7; k++) begin
            run_batch(vecs[k].d, vecs[k].n, vecs[k].c,
                      vecs[k].sum, vecs[k].ovf, 1'b0);
            step();
        end

        // gaps with a stray start in the middle of the batch
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        c_v[0] = 4'd3;
        for (int i = 0; i < 7; i++) begin
            iv_v[0]    = (i == 0 || i == 3 || i == 5 || i == 6);
            start_v[0] = (i == 2);
            chk("gap_ready", int'(rdy_v[0]), 1);
            step();
        end
        iv_v[0]    = 1'b0;
        start_v[0] = 1'b0;
        chk("gap_done_ready", int'(rdy_v[0]), 0);
        step();
        chk("gap_sv", int'(sv_v[0]), 1);
        chk("gap_sum", sum_v[0], 12);
        step();
        chk("gap_idle", int'(busy_v[0]), 0);

        // asynchronous reset partway through a batch
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        c_v[0]  = 4'd5;
        iv_v[0] = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum_v[0], 0);
        chk("mid_rst_ready", int'(rdy_v[0]), 0);
        chk("mid_rst_busy", int'(busy_v[0]), 0);
        chk("mid_rst_ovf_b", int'(ovf_v[1]), 0);
        iv_v[0] = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_sv", int'(sv_v[0]), 0);
        end
        run_batch(0, 4, {4'd4, 4'd3, 4'd2, 4'd1}, 10, 0, 1'b0);

        // products offered while idle must be ignored
        c_v[0]  = 4'd9;
        iv_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_ready", int'(rdy_v[0]), 0);
            chk("idle_sum", sum_v[0], 10);
        end
        iv_v[0] = 1'b0;
        step();
        // in_valid stays high with C=9 through DONE and after
        run_batch(0, 4, {4'd1, 4'd1, 4'd1, 4'd1}, 4, 0, 1'b1);
        c_v[0]  = 4'd9;
        iv_v[0] = 1'b1;
        step();
        chk("post_ready", int'(rdy_v[0]), 0);
        chk("post_sum", sum_v[0], 4);
        iv_v[0] = 1'b0;

        // single-beat batches back to back
        step();
        start_v[2] = 1'b1;
        step();
        start_v[2] = 1'b0;
        c_v[2]  = 4'd6;
        iv_v[2] = 1'b1;
        step();
        iv_v[2] = 1'b0;
        chk("c1_done_ready", int'(rdy_v[2]), 0);
        step();
        chk("c1_sv", int'(sv_v[2]), 1);
        chk("c1_sum", sum_v[2], 6);
        start_v[2] = 1'b1;
        step();
        start_v[2] = 1'b0;
        chk("c2_ready", int'(rdy_v[2]), 1);
        c_v[2]  = 4'd3;
        iv_v[2] = 1'b1;
        step();
        iv_v[2] = 1'b0;
        step();
        chk("c2_sv", int'(sv_v[2]), 1);
        chk("c2_sum", sum_v[2], 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
